// File: rtl/xor_gate.sv
// Two-input XOR as an explicit AND-inverter graph, with a registered copy of the
// result and a sticky flag that latches any disagreement with a behavioural XOR.
module xor_gate (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic c,
  output logic c_q,
  output logic err
);

  logic n1;
  logic n2;
  logic ref_c;
  logic mismatch;

  // AIG nodes: only 2-input ANDs and inversions, kept as named nets so they stay observable.
  assign n1 = a & ~b;
  assign n2 = ~a & b;
  assign c  = ~(~n1 & ~n2);

  // Behavioural reference, deliberately independent of the AIG nodes above.
  assign ref_c    = a ^ b;
  assign mismatch = c ^ ref_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= 1'b0;
      err <= 1'b0;
    end else begin
      c_q <= c;
      // An unknown mismatch must not set the flag; only a definite 1 counts.
      if (mismatch === 1'b1) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xor_gate.sv
// Randomized bench for xor_gate: a parity-based reference model tracks c, c_q and err,
// with directed literal checks for the no-clock, reset, force and async-reset cases.
module tb_xor_gate;

  logic clk      = 1'b0;
  logic clk_en   = 1'b0;
  logic rst;
  logic a        = 1'b0;
  logic b        = 1'b0;
  logic chk_en   = 1'b0;
  logic force_n1 = 1'b0;
  logic exp_cq   = 1'b0;
  logic exp_err  = 1'b0;
  wire  c;
  wire  c_q;
  wire  err;

  int checks = 0;
  int errors = 0;

  xor_gate dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .c_q (c_q),
    .err (err)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Odd parity of the two operands; a forced n1=1 drives the AIG output high.
  function automatic logic parity(input logic x, input logic y);
    return ((int'(x) + int'(y)) % 2) == 1;
  endfunction

  function automatic logic model_c(input logic x, input logic y, input logic f);
    return f ? 1'b1 : parity(x, y);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst === 1'b1) begin
      exp_cq  <= 1'b0;
      exp_err <= 1'b0;
    end else begin
      exp_cq  <= model_c(a, b, force_n1);
      exp_err <= exp_err | (model_c(a, b, force_n1) != parity(a, b));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("c_model",   c,   model_c(a, b, force_n1));
      check("cq_model",  c_q, exp_cq);
      check("err_model", err, exp_err);
    end
  end

  logic [1:0] pat [4];
  logic       lit [4];

  initial begin
    pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b10;
    lit[0] = 1'b0;  lit[1] = 1'b1;  lit[2] = 1'b0;  lit[3] = 1'b1;

    // No clock, reset left undriven.
    a = 0; b = 0; #10 check("nc_00", c, 1'b0);
    a = 1; b = 0; #10 check("nc_10", c, 1'b1);
    a = 1; b = 1; #10 check("nc_11", c, 1'b0);
    a = 0; b = 1; #10 check("nc_01", c, 1'b1);

    // Reset held, inputs toggling.
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      a = 1'($urandom);
      b = 1'($urandom);
      #3;
      check("rst_c",   c,   parity(a, b));
      check("rst_cq",  c_q, 1'b0);
      check("rst_err", err, 1'b0);
    end

    // Release reset and clock the four combinations.
    clk_en = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1 {a, b} = pat[i];
      @(posedge clk); #1;
      check("pat_cq",  c_q, lit[i]);
      check("pat_err", err, 1'b0);
    end

    // Random operation.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      a = 1'($urandom);
      b = 1'($urandom);
    end

    // Corrupt the AIG node and confirm the sticky flag.
    @(negedge clk); #1;
    a = 0; b = 0;
    force dut.n1 = 1'b1;
    force_n1 = 1'b1;
    #1 check("force_c", c, 1'b1);
    @(posedge clk); #1 check("force_err", err, 1'b1);
    @(negedge clk); #1;
    release dut.n1;
    force_n1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      a = 1'($urandom);
      b = 1'($urandom);
    end
    @(posedge clk); #1 check("sticky_err", err, 1'b1);
    @(negedge clk); #1 rst = 1'b1;
    #1 check("clr_err", err, 1'b0);
    rst = 1'b0;

    // Asynchronous reset between edges while c_q is high.
    @(negedge clk); #1 a = 1; b = 0;
    @(posedge clk); #1 check("pre_cq", c_q, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_cq", c_q, 1'b0);
    check("async_c",  c,   1'b1);
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      a = 1'($urandom);
      b = 1'($urandom);
    end
    @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
